// File: rtl/sata_oob_seq.sv
// SATA OOB sequencer: emits COMRESET/COMINIT/COMWAKE bursts, classifies RX
// squelch gaps to detect incoming OOB signals, and runs the ALIGN handshake
// before handing TX to the link layer. All timing is in i_clk cycles.
module sata_oob_seq #(
    parameter bit          OPT_HOST     = 1'b1,
    parameter int unsigned BURST_CK     = 24,
    parameter int unsigned WAKE_IDLE_CK = 24,
    parameter int unsigned INIT_IDLE_CK = 48,
    parameter int unsigned N_BURSTS     = 6,
    parameter int unsigned DET_GAPS     = 4,
    parameter int unsigned WAKE_MIN     = 15,
    parameter int unsigned WAKE_MAX     = 26,
    parameter int unsigned INIT_MIN     = 43,
    parameter int unsigned INIT_MAX     = 53,
    parameter int unsigned RETRY_CK     = 65536,
    parameter int unsigned CW           = 17
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx_elec_idle,
    input  logic       i_rx_align,
    input  logic       i_restart,
    output logic       o_tx_elec_idle,
    output logic [1:0] o_tx_sel,
    output logic       o_link_up,
    output logic       o_init_det,
    output logic       o_wake_det,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_SEND_INIT = 3'd0,
        S_WAIT_INIT = 3'd1,
        S_SEND_WAKE = 3'd2,
        S_WAIT_WAKE = 3'd3,
        S_ALIGN     = 3'd4,
        S_UP        = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_WAKE = 2'd1,
        G_INIT = 2'd2
    } gap_t;

    localparam state_t RST_STATE = OPT_HOST ? S_SEND_INIT : S_WAIT_INIT;

    localparam int unsigned RW = $clog2(DET_GAPS + 1);
    localparam int unsigned NW = $clog2(N_BURSTS + 1);

    localparam logic [CW-1:0] BURST_END = CW'(BURST_CK - 1);
    localparam logic [CW-1:0] WAKE_END  = CW'(WAKE_IDLE_CK - 1);
    localparam logic [CW-1:0] INIT_END  = CW'(INIT_IDLE_CK - 1);
    localparam logic [CW-1:0] WAKE_LO   = CW'(WAKE_MIN);
    localparam logic [CW-1:0] WAKE_HI   = CW'(WAKE_MAX);
    localparam logic [CW-1:0] INIT_LO   = CW'(INIT_MIN);
    localparam logic [CW-1:0] INIT_HI   = CW'(INIT_MAX);
    localparam logic [CW-1:0] RETRY_END = CW'(RETRY_CK - 1);
    localparam logic [NW-1:0] NB_LAST   = NW'(N_BURSTS - 1);
    localparam logic [RW-1:0] RUN_SAT   = RW'(DET_GAPS);

    // ---------------------------------------------------------------
    // RX gap meter
    // ---------------------------------------------------------------
    logic [CW-1:0] idle_cnt;
    logic [RW-1:0] run_cnt;
    gap_t          last_class;
    gap_t          gap_class;
    logic          det_init;
    logic          det_wake;

    // Classify the current idle count and spot the detection point
    always_comb begin
        gap_class = G_NONE;
        if (idle_cnt >= WAKE_LO && idle_cnt <= WAKE_HI) begin
            gap_class = G_WAKE;
        end else if (idle_cnt >= INIT_LO && idle_cnt <= INIT_HI) begin
            gap_class = G_INIT;
        end
        // Detection fires on the cycle the idle count steps past the class MAX,
        // i.e. the trailing idle is too long to be another gap of the sequence.
        det_init = i_rx_elec_idle && (run_cnt >= RUN_SAT) &&
                   (last_class == G_INIT) && (idle_cnt == INIT_HI);
        det_wake = i_rx_elec_idle && (run_cnt >= RUN_SAT) &&
                   (last_class == G_WAKE) && (idle_cnt == WAKE_HI);
    end

    // Count squelch gaps, track same-class runs and pulse detections
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            idle_cnt   <= '0;
            run_cnt    <= '0;
            last_class <= G_NONE;
            o_init_det <= 1'b0;
            o_wake_det <= 1'b0;
        end else begin
            o_init_det <= det_init;
            o_wake_det <= det_wake;
            if (i_rx_elec_idle) begin
                if (idle_cnt != '1) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
                if (det_init || det_wake) begin
                    run_cnt <= '0;
                end
            end else begin
                idle_cnt <= '0;
                if (idle_cnt != '0) begin
                    last_class <= gap_class;
                    if (gap_class == G_NONE) begin
                        run_cnt <= '0;
                    end else if (gap_class == last_class) begin
                        if (run_cnt != RUN_SAT) begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end else begin
                        run_cnt <= RW'(1);
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // FSM, TX burst engine, timeout timer
    // ---------------------------------------------------------------
    state_t        state;
    state_t        state_nxt;
    logic          start_q;
    logic          eng_busy;
    logic          eng_on;
    logic [CW-1:0] eng_cnt;
    logic [NW-1:0] eng_nb;
    logic [CW-1:0] idle_end;
    logic          tx_done;
    logic [CW-1:0] timer;
    logic          timed;
    logic          timeout;
    logic          align_seen;
    logic          nxt_is_send;
    logic          in_send;

    // Engine/timer status decoded from the current state
    always_comb begin
        in_send     = (state == S_SEND_INIT) || (state == S_SEND_WAKE);
        nxt_is_send = (state_nxt == S_SEND_INIT) || (state_nxt == S_SEND_WAKE);
        idle_end    = (state == S_SEND_WAKE) ? WAKE_END : INIT_END;
        tx_done     = eng_busy && !eng_on && (eng_cnt == idle_end) &&
                      (eng_nb == NB_LAST);
        timed       = (state == S_WAIT_WAKE) || (state == S_ALIGN) ||
                      (OPT_HOST && (state == S_WAIT_INIT));
        timeout     = timed && (timer == RETRY_END);
    end

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; later overrides give restart > detection > timeout
    always_comb begin
        state_nxt = state;
        case (state)
            S_SEND_INIT: begin
                if (tx_done) state_nxt = OPT_HOST ? S_WAIT_INIT : S_WAIT_WAKE;
            end
            S_WAIT_INIT: begin
                if (o_init_det)   state_nxt = OPT_HOST ? S_SEND_WAKE : S_SEND_INIT;
                else if (timeout) state_nxt = RST_STATE;
            end
            S_SEND_WAKE: begin
                if (tx_done) state_nxt = OPT_HOST ? S_WAIT_WAKE : S_ALIGN;
            end
            S_WAIT_WAKE: begin
                if (o_wake_det)   state_nxt = OPT_HOST ? S_ALIGN : S_SEND_WAKE;
                else if (timeout) state_nxt = RST_STATE;
            end
            S_ALIGN: begin
                if (OPT_HOST ? align_seen : i_rx_align) state_nxt = S_UP;
                else if (timeout)                       state_nxt = RST_STATE;
            end
            S_UP: begin
                if (o_init_det) state_nxt = RST_STATE;
            end
            default: state_nxt = RST_STATE;
        endcase
        if (!OPT_HOST && o_init_det && !in_send) begin
            state_nxt = S_SEND_INIT;
        end
        if (i_restart) begin
            state_nxt = RST_STATE;
        end
    end

    // Entry flag for send states and the host's ALIGN sub-phase tracker
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            start_q    <= OPT_HOST;
            align_seen <= 1'b0;
        end else begin
            // A restart into the same send state must retrigger the engine.
            start_q    <= nxt_is_send && ((state_nxt != state) || i_restart);
            align_seen <= (state_nxt == S_ALIGN) &&
                          (align_seen || ((state == S_ALIGN) && i_rx_align));
        end
    end

    // Burst engine: BURST_CK on, idle_end+1 off, N_BURSTS times
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            eng_busy <= 1'b0;
            eng_on   <= 1'b0;
            eng_cnt  <= '0;
            eng_nb   <= '0;
        end else if (i_restart || (state_nxt != state)) begin
            eng_busy <= 1'b0;
            eng_on   <= 1'b0;
            eng_cnt  <= '0;
            eng_nb   <= '0;
        end else if (start_q) begin
            eng_busy <= 1'b1;
            eng_on   <= 1'b1;
            eng_cnt  <= '0;
            eng_nb   <= '0;
        end else if (eng_busy) begin
            if (eng_on) begin
                if (eng_cnt == BURST_END) begin
                    eng_on  <= 1'b0;
                    eng_cnt <= '0;
                end else begin
                    eng_cnt <= eng_cnt + 1'b1;
                end
            end else if (eng_cnt == idle_end) begin
                eng_cnt <= '0;
                if (eng_nb == NB_LAST) begin
                    eng_busy <= 1'b0;
                end else begin
                    eng_nb <= eng_nb + 1'b1;
                    eng_on <= 1'b1;
                end
            end else begin
                eng_cnt <= eng_cnt + 1'b1;
            end
        end
    end

    // Time spent in a waiting state, restarted on every state change
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            timer <= '0;
        end else if (i_restart || (state_nxt != state)) begin
            timer <= '0;
        end else if (timed) begin
            timer <= timer + 1'b1;
        end
    end

    // Output decode from state and engine phase
    always_comb begin
        o_tx_elec_idle = 1'b1;
        o_tx_sel       = 2'd0;
        o_link_up      = 1'b0;
        case (state)
            S_SEND_INIT, S_SEND_WAKE: begin
                o_tx_elec_idle = !(eng_busy && eng_on);
            end
            S_ALIGN: begin
                o_tx_elec_idle = 1'b0;
                o_tx_sel       = (OPT_HOST && !align_seen) ? 2'd1 : 2'd0;
            end
            S_UP: begin
                o_tx_elec_idle = 1'b0;
                o_tx_sel       = 2'd2;
                o_link_up      = 1'b1;
            end
            default: begin
                o_tx_elec_idle = 1'b1;
            end
        endcase
    end

    assign o_state = state;

endmodule

// File: tb/tb_sata_oob_seq.sv
// Bench for sata_oob_seq: one host and one device instance, each driven
// through its OOB sequence with scoreboarded burst lengths and detections.
module tb_sata_oob_seq;

    localparam logic [2:0] ST_SEND_INIT = 3'd0;
    localparam logic [2:0] ST_WAIT_INIT = 3'd1;
    localparam logic [2:0] ST_SEND_WAKE = 3'd2;
    localparam logic [2:0] ST_WAIT_WAKE = 3'd3;
    localparam logic [2:0] ST_ALIGN     = 3'd4;
    localparam logic [2:0] ST_UP        = 3'd5;
    localparam int RETRY = 1000;
    localparam int NB    = 6;
    localparam int BURST = 24;

    logic clk = 1'b0;
    logic h_rst, d_rst;
    logic h_rx_idle = 1'b1, d_rx_idle = 1'b1;
    logic h_align = 1'b0, d_align = 1'b0;
    logic h_restart = 1'b0, d_restart = 1'b0;
    logic h_tx_idle, d_tx_idle;
    logic [1:0] h_sel, d_sel;
    logic h_link, d_link;
    logic h_init, d_init, h_wake, d_wake;
    logic [2:0] h_state, d_state;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    sata_oob_seq #(.OPT_HOST(1'b1), .RETRY_CK(RETRY)) u_host (
        .i_clk(clk), .i_reset(h_rst), .i_rx_elec_idle(h_rx_idle),
        .i_rx_align(h_align), .i_restart(h_restart),
        .o_tx_elec_idle(h_tx_idle), .o_tx_sel(h_sel), .o_link_up(h_link),
        .o_init_det(h_init), .o_wake_det(h_wake), .o_state(h_state)
    );

    sata_oob_seq #(.OPT_HOST(1'b0), .RETRY_CK(RETRY)) u_dev (
        .i_clk(clk), .i_reset(d_rst), .i_rx_elec_idle(d_rx_idle),
        .i_rx_align(d_align), .i_restart(d_restart),
        .o_tx_elec_idle(d_tx_idle), .o_tx_sel(d_sel), .o_link_up(d_link),
        .o_init_det(d_init), .o_wake_det(d_wake), .o_state(d_state)
    );

    function automatic logic get_idle(input bit dev);
        return dev ? d_tx_idle : h_tx_idle;
    endfunction
    function automatic logic [2:0] get_state(input bit dev);
        return dev ? d_state : h_state;
    endfunction
    function automatic logic [1:0] get_sel(input bit dev);
        return dev ? d_sel : h_sel;
    endfunction
    function automatic logic get_det(input bit dev, input bit wake);
        if (dev) return wake ? d_wake : d_init;
        return wake ? h_wake : h_init;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_rx(input bit dev, input logic v);
        if (dev) d_rx_idle = v;
        else     h_rx_idle = v;
    endtask

    // One RX burst; line left idle afterwards
    task automatic rx_on(input bit dev);
        set_rx(dev, 1'b0);
        repeat (BURST) tick();
        set_rx(dev, 1'b1);
    endtask

    task automatic rx_seq(input bit dev, input int g0, input int g1,
                          input int g2, input int g3, input int g4);
        int gaps[5];
        gaps = '{g0, g1, g2, g3, g4};
        for (int i = 0; i < 5; i++) begin
            if (gaps[i] > 0) begin
                rx_on(dev);
                repeat (gaps[i]) tick();
            end
        end
        rx_on(dev);
    endtask

    // Measure TX on/off run lengths of one send state against the queue
    task automatic measure_bursts(input bit dev, input logic [2:0] st,
                                  input int idle_len, input string name);
        int guard, run, e, bad_sel;
        logic cur;
        for (int b = 0; b < NB; b++) begin
            exp_q.push_back(BURST);
            exp_q.push_back(idle_len);
        end
        guard = 0;
        bad_sel = 0;
        while (!(get_state(dev) == st && get_idle(dev) == 1'b0) && guard < 2500) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 2500) begin
            errors++;
            $display("FAIL %s_start: no burst seen, state=%0d", name, get_state(dev));
        end
        while (get_state(dev) == st && guard < 5000) begin
            cur = get_idle(dev);
            run = 0;
            while (get_state(dev) == st && get_idle(dev) == cur && guard < 5000) begin
                if (!cur && get_sel(dev) != 2'd0) bad_sel++;
                run++;
                tick();
                guard++;
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s_extra: extra run of %0d cycles, expected none", name, run);
            end else begin
                e = exp_q.pop_front();
                if (run !== e) begin
                    errors++;
                    $display("FAIL %s_run: got %0d cycles, expected %0d", name, run, e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_count: %0d runs missing, expected 0", name, exp_q.size());
        end
        exp_q.delete();
        checks++;
        if (bad_sel != 0) begin
            errors++;
            $display("FAIL %s_sel: %0d burst cycles with sel!=0, expected 0", name, bad_sel);
        end
    endtask

    // Watch trailing idle for a detection pulse at idle count exp_k (0 = none)
    task automatic watch_det(input bit dev, input bit wake, input int exp_k,
                             input logic [2:0] exp_st, input int max_k,
                             input string name);
        int k, seen, other, e;
        bit done;
        logic [2:0] st;
        exp_q.push_back(exp_k);
        k = 0; seen = 0; other = 0; done = 0;
        while (k < max_k && !done) begin
            tick();
            k++;
            if (get_det(dev, wake) && seen == 0) seen = k;
            if (get_det(dev, !wake)) other++;
            if (seen != 0 && k == seen + 1) done = 1;
        end
        st = get_state(dev);
        e = exp_q.pop_front();
        checks++;
        if (seen !== e) begin
            errors++;
            $display("FAIL %s_k: detect at idle=%0d, expected %0d", name, seen, e);
        end
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL %s_state: got %0d, expected %0d", name, st, exp_st);
        end
        checks++;
        if (other != 0) begin
            errors++;
            $display("FAIL %s_other: %0d wrong-type pulses, expected 0", name, other);
        end
    endtask

    task automatic test_reset();
        h_rst = 1'b1;
        d_rst = 1'b1;
        repeat (3) tick();
        checks++; if (h_tx_idle !== 1'b1) begin errors++; $display("FAIL rst_tx_idle: got %0b expected 1", h_tx_idle); end
        checks++; if (h_sel !== 2'd0) begin errors++; $display("FAIL rst_sel: got %0d expected 0", h_sel); end
        checks++; if (h_link !== 1'b0) begin errors++; $display("FAIL rst_link: got %0b expected 0", h_link); end
        checks++; if ({h_init, h_wake, d_init, d_wake} !== 4'b0) begin errors++; $display("FAIL rst_pulses: got %b expected 0000", {h_init, h_wake, d_init, d_wake}); end
        checks++; if (h_state !== ST_SEND_INIT) begin errors++; $display("FAIL rst_host_state: got %0d expected %0d", h_state, ST_SEND_INIT); end
        checks++; if (d_state !== ST_WAIT_INIT) begin errors++; $display("FAIL rst_dev_state: got %0d expected %0d", d_state, ST_WAIT_INIT); end
        checks++; if (d_tx_idle !== 1'b1) begin errors++; $display("FAIL rst_dev_tx_idle: got %0b expected 1", d_tx_idle); end
        h_rst = 1'b0;
        d_rst = 1'b0;
    endtask

    task automatic test_host_timeout();
        int n;
        n = 0;
        while (h_state == ST_WAIT_INIT && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (n !== RETRY) begin
            errors++;
            $display("FAIL host_timeout_len: got %0d cycles, expected %0d", n, RETRY);
        end
        checks++;
        if (h_state !== ST_SEND_INIT) begin
            errors++;
            $display("FAIL host_timeout_state: got %0d, expected %0d", h_state, ST_SEND_INIT);
        end
        measure_bursts(1'b0, ST_SEND_INIT, 48, "host_resend");
    endtask

    task automatic test_host_align();
        checks++; if ({h_tx_idle, h_sel} !== 3'b001) begin errors++; $display("FAIL align_d102: got idle/sel %b, expected 001", {h_tx_idle, h_sel}); end
        repeat (3) tick();
        checks++; if (h_sel !== 2'd1) begin errors++; $display("FAIL align_hold: got sel %0d, expected 1", h_sel); end
        h_align = 1'b1;
        tick();
        h_align = 1'b0;
        checks++; if ({h_state, h_sel} !== {ST_ALIGN, 2'd0}) begin errors++; $display("FAIL align_sel0: got state %0d sel %0d, expected %0d 0", h_state, h_sel, ST_ALIGN); end
        tick();
        checks++; if (h_state !== ST_UP) begin errors++; $display("FAIL align_up: got %0d, expected %0d", h_state, ST_UP); end
        checks++; if ({h_tx_idle, h_sel, h_link} !== 4'b0101) begin errors++; $display("FAIL up_outputs: got idle/sel/link %b, expected 0101", {h_tx_idle, h_sel, h_link}); end
    endtask

    task automatic test_host_reinit();
        rx_seq(1'b0, 48, 48, 48, 48, 48);
        watch_det(1'b0, 1'b0, 54, ST_SEND_INIT, 80, "host_reinit");
        checks++;
        if (h_link !== 1'b0) begin
            errors++;
            $display("FAIL reinit_link: got %0b, expected 0", h_link);
        end
    endtask

    task automatic test_restart_mid_burst();
        int guard;
        guard = 0;
        while (h_tx_idle != 1'b0 && guard < 100) begin tick(); guard++; end
        repeat (5) tick();
        h_restart = 1'b1;
        tick();
        h_restart = 1'b0;
        checks++;
        if ({h_tx_idle, h_state} !== {1'b1, ST_SEND_INIT}) begin
            errors++;
            $display("FAIL restart_abort: got idle %0b state %0d, expected 1 %0d", h_tx_idle, h_state, ST_SEND_INIT);
        end
        measure_bursts(1'b0, ST_SEND_INIT, 48, "host_restart");
    endtask

    task automatic test_reset_mid_burst();
        int guard;
        guard = 0;
        while (!(h_state == ST_SEND_INIT && h_tx_idle == 1'b0) && guard < 1500) begin tick(); guard++; end
        repeat (3) tick();
        checks++;
        if (h_tx_idle !== 1'b0) begin
            errors++;
            $display("FAIL reset_pre: got idle %0b, expected 0 mid-burst", h_tx_idle);
        end
        h_rst = 1'b1;
        #1;
        checks++;
        if ({h_tx_idle, h_state} !== {1'b1, ST_SEND_INIT}) begin
            errors++;
            $display("FAIL reset_abort: got idle %0b state %0d, expected 1 %0d", h_tx_idle, h_state, ST_SEND_INIT);
        end
        tick();
        h_rst = 1'b0;
    endtask

    task automatic test_dev_no_detect();
        rx_seq(1'b1, 48, 48, 24, 48, 0);
        watch_det(1'b1, 1'b0, 0, ST_WAIT_INIT, 80, "dev_broken_run");
        rx_seq(1'b1, 48, 48, 48, 0, 0);
        watch_det(1'b1, 1'b0, 0, ST_WAIT_INIT, 80, "dev_three_gaps");
    endtask

    task automatic test_dev_sequence();
        rx_seq(1'b1, 48, 48, 48, 48, 48);
        watch_det(1'b1, 1'b0, 54, ST_SEND_INIT, 80, "dev_init");
        measure_bursts(1'b1, ST_SEND_INIT, 48, "dev_cominit");
        checks++;
        if (d_state !== ST_WAIT_WAKE) begin
            errors++;
            $display("FAIL dev_wait_wake: got %0d, expected %0d", d_state, ST_WAIT_WAKE);
        end
        rx_seq(1'b1, 24, 24, 24, 24, 0);
        watch_det(1'b1, 1'b1, 27, ST_SEND_WAKE, 60, "dev_wake");
        measure_bursts(1'b1, ST_SEND_WAKE, 24, "dev_comwake");
        checks++;
        if ({d_state, d_tx_idle, d_sel} !== {ST_ALIGN, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL dev_align: got state %0d idle %0b sel %0d, expected %0d 0 0", d_state, d_tx_idle, d_sel, ST_ALIGN);
        end
        d_align = 1'b1;
        tick();
        d_align = 1'b0;
        checks++;
        if ({d_state, d_sel, d_link} !== {ST_UP, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL dev_up: got state %0d sel %0d link %0b, expected %0d 2 1", d_state, d_sel, d_link, ST_UP);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected run to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        measure_bursts(1'b0, ST_SEND_INIT, 48, "host_comreset");
        test_host_timeout();
        rx_seq(1'b0, 48, 48, 48, 48, 48);
        watch_det(1'b0, 1'b0, 54, ST_SEND_WAKE, 80, "host_init");
        measure_bursts(1'b0, ST_SEND_WAKE, 24, "host_comwake");
        rx_seq(1'b0, 24, 24, 24, 24, 0);
        watch_det(1'b0, 1'b1, 27, ST_ALIGN, 60, "host_wake");
        test_host_align();
        test_host_reinit();
        test_restart_mid_burst();
        test_reset_mid_burst();
        test_dev_no_detect();
        test_dev_sequence();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
